beta_step_ctrl: RTL and testbench
=================================

Name: beta_step_ctrl

Overview:
- Clock-enable scheduler for the Beta processor core. It decides when the core advances one cycle.
- Modes: halted, single-step from a debounced push-button, free-run at a programmable divided rate, or a counted burst of N steps.
- Replaces a fixed free-running divider. Emits a one-cycle cpu_en strobe in the clk domain plus a 50%-style LED toggle for board visibility.

Parameters:
- CNT_W, 32: width of the prescaler counter and divisor register.
- DEFAULT_DIV, 50000000: divisor loaded at reset. One free-run step every DEFAULT_DIV clk cycles.
- BURST_W, 16: width of the burst length and remaining-count register.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- mode  in  2  00 halt, 01 single-step, 10 free-run, 11 burst
- step_req  in  1  debounced, synchronised step button (level)
- div_val  in  CNT_W  new divisor value
- div_load  in  1  one-cycle strobe: latch div_val
- burst_len  in  BURST_W  number of steps for a burst
- burst_start  in  1  one-cycle strobe: begin burst (mode 11 only)
- cpu_en  out  1  one-cycle clock-enable to the core (registered)
- slow_clk  out  1  toggles on every cpu_en (LED)
- busy  out  1  high when FSM is not IDLE
- burst_done  out  1  one-cycle pulse when a burst completes normally

Behaviour:
- Reset (rst high at clk edge) sets all of the following. All outputs are 0 one cycle after reset asserts:
  - state=IDLE, div_reg=DEFAULT_DIV, count=0, remaining=0, step_prev=0.
  - cpu_en=0, slow_clk=0, busy=0, burst_done=0.
- Reset mid-run or mid-burst aborts immediately. No burst_done is issued.
- Divisor:
  - div_load latches div_val. A div_val of 0 is clamped to 1.
  - div_load also clears count to 0.
  - If div_load coincides with a prescaler terminal count, the load wins and no tick is issued that cycle.
- Prescaler:
  - Counts 0..div_reg-1 only while state is RUN or BURST. It is held at 0 in IDLE/STEP.
  - tick = (count == div_reg-1). count wraps to 0 on tick.
  - With div_reg=1, tick occurs every cycle.
- Step edge detect: step_prev <= step_req every cycle; step_edge = step_req & ~step_prev. Holding the button produces exactly one step.
- FSM:
  - IDLE:
    - mode==01 and step_edge -> STEP.
    - mode==10 -> RUN.
    - mode==11 and burst_start: if burst_len==0, pulse burst_done and stay IDLE; else remaining<=burst_len and go to BURST.
    - Otherwise stay in IDLE.
  - STEP: cpu_en=1 for exactly this one cycle, then IDLE. Total latency is 2 cycles from step_req rising at the input to cpu_en high.
  - RUN:
    - While mode==10, cpu_en pulses on the cycle after each tick (registered output).
    - When mode!=10, go to IDLE the next cycle and suppress any tick in the exit cycle.
  - BURST:
    - On each tick, issue cpu_en and decrement remaining.
    - When the tick arrives with remaining==1: issue the final cpu_en, pulse burst_done in the same cycle as cpu_en, and go to IDLE.
    - If mode!=11, abort to IDLE with no cpu_en and no burst_done.
    - burst_start while already in BURST is ignored.
- Output rules:
  - slow_clk toggles in the same cycle cpu_en is high.
  - busy is high in STEP, RUN and BURST.
  - cpu_en is never high in two consecutive cycles unless div_reg==1 in RUN/BURST.
- Mode changes while in IDLE take effect the following cycle. step_req is ignored outside mode 01.

Test Plan:
- Reset, then hold for 10 cycles in mode 00 -> cpu_en, slow_clk, busy, burst_done all 0. div_reg reads 50000000 (DEFAULT_DIV; the bench overrides to 4, expect 4).
- Mode 01, step_req held high for 20 cycles -> exactly one cpu_en pulse, 2 cycles after the rise. slow_clk 0->1. A second press gives a second pulse and slow_clk returns to 0.
- Mode 10, div_load with div_val=5 -> cpu_en pulses every 5 cycles. 4 pulses in 20 cycles. Switch to mode 00 -> no further pulses and busy drops within 1 cycle.
- Mode 11, div_val=3, burst_len=4, burst_start -> exactly 4 cpu_en pulses spaced 3 cycles apart. burst_done coincides with the 4th pulse. busy is 0 one cycle later.
- Burst of 10 aborted by switching to mode 00 after the 3rd pulse -> exactly 3 pulses, no burst_done. Also burst_len=0 -> burst_done pulse, busy stays 0, no cpu_en.
- div_load with div_val=0 during RUN, and div_load on a terminal-count cycle -> divisor becomes 1 (cpu_en every cycle). No tick in the load cycle. rst asserted mid-burst clears all outputs next cycle.

Source files
------------

// File: rtl/beta_step_ctrl.sv
// rtl/beta_step_ctrl.sv - clock-enable scheduler for the Beta core: halt, single-step, free-run, burst
module beta_step_ctrl #(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 50000000,
    parameter int BURST_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               step_req,
    input  logic [CNT_W-1:0]   div_val,
    input  logic               div_load,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               burst_start,
    output logic               cpu_en,
    output logic               slow_clk,
    output logic               busy,
    output logic               burst_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STEP  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_BURST = 2'd3;

    localparam logic [1:0] M_STEP  = 2'd1;
    localparam logic [1:0] M_RUN   = 2'd2;
    localparam logic [1:0] M_BURST = 2'd3;

    localparam logic [CNT_W-1:0]   DIV_INIT = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [BURST_W-1:0] REM_ONE  = BURST_W'(1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   div_reg;
    logic [CNT_W-1:0]   count;
    logic [BURST_W-1:0] remaining;
    logic [BURST_W-1:0] rem_nxt;
    logic               step_prev;
    logic               step_edge;
    logic               counting;
    logic               tick;
    logic               en_nxt;
    logic               done_nxt;
    logic               keep_counting;

    assign step_edge = step_req & ~step_prev;
    assign counting  = (state == S_RUN) || (state == S_BURST);
    // A divisor load restarts the period, so it masks a coincident terminal count.
    assign tick      = counting && !div_load && (count == div_reg - CNT_ONE);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        en_nxt    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (mode == M_STEP && step_edge) begin
                    state_nxt = S_STEP;
                end else if (mode == M_RUN) begin
                    state_nxt = S_RUN;
                end else if (mode == M_BURST && burst_start) begin
                    if (burst_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        rem_nxt   = burst_len;
                        state_nxt = S_BURST;
                    end
                end
            end
            S_STEP: begin
                en_nxt    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (mode != M_RUN) begin
                    state_nxt = S_IDLE;
                end else if (tick) begin
                    en_nxt = 1'b1;
                end
            end
            S_BURST: begin
                // Leaving burst mode aborts silently: no final enable, no done pulse.
                if (mode != M_BURST) begin
                    state_nxt = S_IDLE;
                end else if (tick) begin
                    en_nxt  = 1'b1;
                    rem_nxt = remaining - REM_ONE;
                    if (remaining == REM_ONE) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign keep_counting = counting && ((state_nxt == S_RUN) || (state_nxt == S_BURST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            div_reg    <= DIV_INIT;
            count      <= '0;
            remaining  <= '0;
            step_prev  <= 1'b0;
            cpu_en     <= 1'b0;
            slow_clk   <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            remaining  <= rem_nxt;
            step_prev  <= step_req;
            cpu_en     <= en_nxt;
            slow_clk   <= slow_clk ^ en_nxt;
            burst_done <= done_nxt;
            if (div_load || tick || !keep_counting) begin
                count <= '0;
            end else begin
                count <= count + CNT_ONE;
            end
            if (div_load) begin
                div_reg <= (div_val == '0) ? CNT_ONE : div_val;
            end
        end
    end

endmodule

// File: tb/tb_beta_step_ctrl.sv
// tb/tb_beta_step_ctrl.sv - self-checking bench for beta_step_ctrl
module tb_beta_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        step_req;
    logic [31:0] div_val;
    logic        div_load;
    logic [15:0] burst_len;
    logic        burst_start;
    logic        cpu_en;
    logic        slow_clk;
    logic        busy;
    logic        burst_done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    beta_step_ctrl #(.CNT_W(32), .DEFAULT_DIV(4), .BURST_W(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .step_req(step_req),
        .div_val(div_val), .div_load(div_load), .burst_len(burst_len),
        .burst_start(burst_start), .cpu_en(cpu_en), .slow_clk(slow_clk),
        .busy(busy), .burst_done(burst_done)
    );

    // Reference: phase 0 idle, 1 step, 2 run, 3 burst; ticks derived from
    // cycles elapsed since the period started, modulo the divisor.
    int m_ph, m_div, m_elapsed, m_left;
    bit m_prev, m_slow, m_en, m_done;

    task automatic model_step();
        bit edge_s, tk;
        if (rst) begin
            m_ph = 0; m_div = 4; m_elapsed = 0; m_left = 0;
            m_prev = 0; m_slow = 0; m_en = 0; m_done = 0;
            return;
        end
        m_en = 0; m_done = 0;
        edge_s = step_req && !m_prev;
        m_prev = step_req;
        tk = (m_ph >= 2) && !div_load && (((m_elapsed + 1) % m_div) == 0);
        case (m_ph)
            0: begin
                m_elapsed = 0;
                if (mode == 1 && edge_s) m_ph = 1;
                else if (mode == 2) m_ph = 2;
                else if (mode == 3 && burst_start) begin
                    if (burst_len == 0) m_done = 1;
                    else begin m_left = burst_len; m_ph = 3; end
                end
            end
            1: begin m_en = 1; m_ph = 0; end
            2: begin
                if (mode != 2) m_ph = 0;
                else begin m_en = tk; m_elapsed++; end
            end
            default: begin
                if (mode != 3) m_ph = 0;
                else begin
                    m_elapsed++;
                    if (tk) begin
                        m_en = 1;
                        m_left--;
                        if (m_left == 0) begin m_done = 1; m_ph = 0; end
                    end
                end
            end
        endcase
        if (div_load) begin
            m_div = (div_val == 0) ? 1 : int'(div_val);
            m_elapsed = 0;
        end
        m_slow ^= m_en;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("model", {28'd0, cpu_en, slow_clk, busy, burst_done},
            {28'd0, m_en, m_slow, (m_ph != 0), m_done});
    endtask

    task automatic do_reset();
        rst = 1; mode = 0; step_req = 0; div_load = 0; div_val = 0;
        burst_len = 0; burst_start = 0;
        cyc();
        rst = 0;
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  mode;
        logic        step;
        logic        bs;
        logic [15:0] bl;
        logic [3:0]  exp;   // {cpu_en, slow_clk, busy, burst_done}
    } vec_t;

    vec_t tbl[22];

    int pulses, first_p, last_p, done_cnt, done_at, busy_after;

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 16'd0, 4'b0000};
        tbl[1]  = '{1'b0, 2'd1, 1'b0, 1'b0, 16'd0, 4'b0000};
        tbl[2]  = '{1'b0, 2'd1, 1'b1, 1'b0, 16'd0, 4'b0010};
        tbl[3]  = '{1'b0, 2'd1, 1'b1, 1'b0, 16'd0, 4'b1100};
        tbl[4]  = '{1'b0, 2'd1, 1'b1, 1'b0, 16'd0, 4'b0100};
        tbl[5]  = '{1'b0, 2'd1, 1'b0, 1'b0, 16'd0, 4'b0100};
        tbl[6]  = '{1'b0, 2'd1, 1'b1, 1'b0, 16'd0, 4'b0110};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 1'b0, 16'd0, 4'b1000};
        tbl[8]  = '{1'b0, 2'd3, 1'b0, 1'b1, 16'd0, 4'b0001};
        tbl[9]  = '{1'b0, 2'd3, 1'b0, 1'b0, 16'd0, 4'b0000};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 16'd0, 4'b0000};
        tbl[11] = '{1'b0, 2'd1, 1'b1, 1'b0, 16'd0, 4'b0000};
        tbl[12] = '{1'b0, 2'd3, 1'b0, 1'b1, 16'd2, 4'b0010};
        tbl[13] = '{1'b0, 2'd3, 1'b0, 1'b0, 16'd2, 4'b0010};
        tbl[14] = '{1'b0, 2'd3, 1'b0, 1'b0, 16'd2, 4'b0010};
        tbl[15] = '{1'b0, 2'd3, 1'b0, 1'b0, 16'd2, 4'b0010};
        tbl[16] = '{1'b0, 2'd3, 1'b0, 1'b0, 16'd2, 4'b1110};
        tbl[17] = '{1'b0, 2'd3, 1'b0, 1'b0, 16'd2, 4'b0110};
        tbl[18] = '{1'b0, 2'd3, 1'b0, 1'b0, 16'd2, 4'b0110};
        tbl[19] = '{1'b0, 2'd3, 1'b0, 1'b0, 16'd2, 4'b0110};
        tbl[20] = '{1'b0, 2'd3, 1'b0, 1'b0, 16'd2, 4'b1001};
        tbl[21] = '{1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 4'b0000};

        rst = 1; mode = 0; step_req = 0; div_val = 0; div_load = 0;
        burst_len = 0; burst_start = 0;
        for (int i = 0; i < 22; i++) begin
            rst = tbl[i].rst; mode = tbl[i].mode; step_req = tbl[i].step;
            burst_start = tbl[i].bs; burst_len = tbl[i].bl;
            cyc();
            chk($sformatf("tbl[%0d]", i), {28'd0, cpu_en, slow_clk, busy, burst_done},
                {28'd0, tbl[i].exp});
        end

        // Halt for 10 cycles, then free-run at the default divisor (4).
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            pulses += int'(cpu_en | slow_clk | busy | burst_done);
        end
        chk("halt_quiet", pulses, 0);
        mode = 2;
        first_p = -1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (cpu_en && first_p < 0) first_p = i;
        end
        chk("default_div_first", first_p, 4);

        // Step held for 20 cycles, then a second press.
        do_reset();
        mode = 1; cyc();
        step_req = 1; pulses = 0; first_p = -1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (cpu_en) begin pulses++; if (first_p < 0) first_p = i; end
        end
        chk("step_hold_pulses", pulses, 1);
        chk("step_latency", first_p, 1);
        chk("step_slow_1", slow_clk, 1);
        step_req = 0; cyc();
        step_req = 1; pulses = 0;
        for (int i = 0; i < 4; i++) begin cyc(); pulses += int'(cpu_en); end
        chk("step2_pulses", pulses, 1);
        chk("step2_slow_0", slow_clk, 0);
        step_req = 0;

        // Free-run, divisor 5.
        do_reset();
        div_load = 1; div_val = 5; cyc();
        div_load = 0; mode = 2; cyc();
        pulses = 0; first_p = -1; last_p = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (cpu_en) begin
                if (last_p >= 0) chk("run_spacing", i - last_p, 5);
                if (first_p < 0) first_p = i;
                last_p = i; pulses++;
            end
        end
        chk("run_pulses", pulses, 4);
        chk("run_first", first_p, 5);
        mode = 0; cyc();
        chk("run_exit_busy", busy, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin cyc(); pulses += int'(cpu_en); end
        chk("run_exit_quiet", pulses, 0);

        // Burst of 4 at divisor 3.
        do_reset();
        div_load = 1; div_val = 3; cyc();
        div_load = 0; mode = 3; burst_len = 4; burst_start = 1; cyc();
        burst_start = 0;
        pulses = 0; first_p = -1; last_p = -1; done_cnt = 0; done_at = -1; busy_after = -1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (cpu_en) begin pulses++; if (first_p < 0) first_p = i; last_p = i; end
            if (burst_done) begin done_cnt++; done_at = i; end
            if (i == 13) busy_after = int'(busy);
        end
        chk("burst_pulses", pulses, 4);
        chk("burst_first", first_p, 3);
        chk("burst_last", last_p, 12);
        chk("burst_done_cnt", done_cnt, 1);
        chk("burst_done_at", done_at, 12);
        chk("burst_busy_after", busy_after, 0);

        // Burst of 10 aborted after the third pulse.
        burst_len = 10; burst_start = 1; cyc();
        burst_start = 0; pulses = 0; done_cnt = 0;
        for (int i = 0; i < 40 && pulses < 3; i++) begin
            cyc();
            pulses += int'(cpu_en); done_cnt += int'(burst_done);
        end
        mode = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            pulses += int'(cpu_en); done_cnt += int'(burst_done);
        end
        chk("abort_pulses", pulses, 3);
        chk("abort_no_done", done_cnt, 0);
        mode = 3; burst_len = 0; burst_start = 1; cyc();
        burst_start = 0;
        chk("zero_len", {28'd0, cpu_en, busy, burst_done}, 32'b001);
        cyc();
        chk("zero_len_after", {28'd0, cpu_en, busy, burst_done}, 32'b000);

        // Divisor 0 loaded on the terminal-count cycle: no tick, then every cycle.
        do_reset();
        mode = 2;
        for (int i = 0; i < 4; i++) cyc();
        div_load = 1; div_val = 0; cyc();
        chk("load_on_tc", cpu_en, 0);
        div_load = 0; pulses = 0;
        for (int i = 0; i < 5; i++) begin cyc(); pulses += int'(cpu_en); end
        chk("div1_every_cycle", pulses, 5);

        // Reset in the middle of a burst.
        div_load = 1; div_val = 2; mode = 0; cyc();
        div_load = 0; mode = 3; burst_len = 5; burst_start = 1; cyc();
        burst_start = 0;
        for (int i = 0; i < 3; i++) cyc();
        rst = 1; cyc();
        chk("rst_mid_burst", {28'd0, cpu_en, slow_clk, busy, burst_done}, 32'd0);
        rst = 0; mode = 0; done_cnt = 0;
        for (int i = 0; i < 5; i++) begin cyc(); done_cnt += int'(burst_done); end
        chk("rst_no_done", done_cnt, 0);

        // Randomized traffic against the reference.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) step_req = ~step_req;
            div_load = ($urandom_range(0, 49) == 0);
            div_val = $urandom_range(0, 4);
            burst_start = ($urandom_range(0, 9) == 0);
            burst_len = 16'($urandom_range(0, 5));
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
